shift_unit_mc: RTL and testbench

- Multicycle shift unit for the pipelined MIPS EX stage; executes SLL/SRL/SRA (plus optional ROTR) by iterative shifting.
- Frees the single-cycle datapath from a full barrel shifter.
- Complements the fixed left-by-2 address shifter with a variable-amount, bidirectional shift.
- Hazard unit stalls the pipeline while the block is busy; a valid/ready handshake returns the result.

---
 rtl/shift_unit_mc_if.sv | 26 ++
 rtl/shift_unit_mc.sv | 106 ++++++++++
 tb/tb_shift_unit_mc.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_mc_if.sv
// Request/result bundle between the EX-stage control and the multicycle shifter.
// The master drives requests and result acceptance; the slave (shifter) returns ready/result.
interface shift_unit_mc_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             flush;
  logic             start;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output flush, start, op, operand, shamt, res_ready,
    input  ready, res_valid, result
  );

  modport slave (
    input  flush, start, op, operand, shamt, res_ready,
    output ready, res_valid, result
  );
endinterface

// File: rtl/shift_unit_mc.sv
// Iterative SLL/SRL/SRA shifter (ROTR on op=10 when SHIFT_ROTATE_EN is defined), up to STEP bits/cycle.
// Latency ceil(shamt/STEP)+1 edges after accept; result held in DONE until res_ready, no queuing.
module shift_unit_mc #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = 5
) (
  input logic           clk,
  input logic           reset,
  shift_unit_mc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       op_q;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [SHW-1:0]   k_d;
  logic             ready_q;
  logic             res_valid_q;

`ifdef SHIFT_ROTATE_EN
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
  logic [SHW:0] rot_amt;
  assign rot_amt = WIDTH_W - {1'b0, k_d};
`endif

  always_comb begin
    k_d    = (rem_q > STEP_W) ? STEP_W : rem_q;
    rem_d  = rem_q - k_d;
    work_d = work_q;
    case (op_q)
      2'b00:   work_d = work_q << k_d;
      // Arithmetic shift keeps replicating the MSB, which is the latched operand's sign bit.
      2'b11:   work_d = $signed(work_q) >>> k_d;
`ifdef SHIFT_ROTATE_EN
      2'b10:   work_d = (work_q >> k_d) | (work_q << rot_amt);
`endif
      default: work_d = work_q >> k_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      result_q    <= '0;
      op_q        <= 2'b00;
      rem_q       <= '0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
    end else if (bus.flush) begin
      // Abort leaves result_q untouched so the last delivered value remains visible.
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q  <= bus.operand;
            op_q    <= bus.op;
            rem_q   <= bus.shamt;
            state_q <= SHIFT;
            ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (rem_q != '0) begin
            work_q <= work_d;
            rem_q  <= rem_d;
          end else begin
            result_q    <= work_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_shift_unit_mc.sv
// Drives four shifters (STEP = 1, 2, 4, 8) with shared directed stimulus and checks each against
// a transaction-level model every cycle, plus literal results and latencies per scenario.
module tb_shift_unit_mc;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, start, res_ready;
  logic [1:0]    op;
  logic [W-1:0]  operand;
  logic [4:0]    shamt;
  logic [N-1:0]  rdy, vld;
  logic [W-1:0]  res [N];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    shift_unit_mc_if #(.WIDTH(W), .SHW(5)) bus ();
    assign bus.flush     = flush;
    assign bus.start     = start;
    assign bus.op        = op;
    assign bus.operand   = operand;
    assign bus.shamt     = shamt;
    assign bus.res_ready = res_ready;
    assign rdy[g]        = bus.ready;
    assign vld[g]        = bus.res_valid;
    assign res[g]        = bus.result;
    shift_unit_mc #(.WIDTH(W), .STEP(1 << g), .SHW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  // Model: 0 idle, 1 busy, 2 done; busy lasts ceil(shamt/STEP)+1 edges.
  int           m_st  [N];
  int           m_cnt [N];
  logic [W-1:0] m_res [N];
  logic [W-1:0] m_pend[N];

  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] x, input int s);
    case (o)
      2'b00:   return x << s;
      2'b11:   return W'($signed(x) >>> s);
`ifdef SHIFT_ROTATE_EN
      2'b10:   return (x >> s) | (x << (W - s));
`endif
      default: return x >> s;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        m_st[i]  = 0;
        m_res[i] = '0;
      end else if (flush) begin
        m_st[i] = 0;
      end else begin
        case (m_st[i])
          0: if (start) begin
               m_pend[i] = ref_shift(op, operand, int'(shamt));
               m_cnt[i]  = (int'(shamt) + (1 << i) - 1) / (1 << i) + 1;
               m_st[i]   = 1;
             end
          1: begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                 m_st[i]  = 2;
                 m_res[i] = m_pend[i];
               end
             end
          default: if (res_ready) m_st[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (rdy[i] !== (m_st[i] == 0) || vld[i] !== (m_st[i] == 2) || res[i] !== m_res[i]) begin
          miscompares++;
          $display("FAIL cycle_model step=%0d t=%0t: ready=%b valid=%b result=%h, required ready=%b valid=%b result=%h",
                   1 << i, $time, rdy[i], vld[i], res[i], m_st[i] == 0, m_st[i] == 2, m_res[i]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  int           lat_seen[N];
  logic [W-1:0] res_seen[N];
  logic [N-1:0] rdy_k1;

  task automatic wait_all_ready();
    int t = 0;
    while (rdy !== '1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rdy !== '1) check("ready_timeout", W'(rdy), W'(4'hF));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [4:0] s,
                        input bit rr, input bit poke);
    bit seen[N];
    bit all;
    int k;
    wait_all_ready();
    op = o; operand = x; shamt = s; res_ready = rr; start = 1'b1;
    for (int i = 0; i < N; i++) begin
      seen[i] = 1'b0; lat_seen[i] = -1; res_seen[i] = 'x;
    end
    all = 1'b0;
    k = 0;
    while (!all && k < 80) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        rdy_k1 = rdy;
        start  = poke;
        if (poke) begin
          op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd1;
        end
      end else begin
        start = 1'b0;
      end
      all = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!seen[i] && vld[i]) begin
          seen[i] = 1'b1; lat_seen[i] = k - 1; res_seen[i] = res[i];
        end
        all &= seen[i];
      end
    end
    if (!all) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_txn(input string name, input logic [W-1:0] exp,
                           input int l0, input int l1, input int l2, input int l3);
    int le[N];
    le = '{l0, l1, l2, l3};
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_result_step%0d", name, 1 << i), res_seen[i], exp);
      check($sformatf("%s_latency_step%0d", name, 1 << i), W'(lat_seen[i]), W'(le[i]));
    end
  endtask

  // Starts a long SLL and applies reset or flush on the edge after the first busy edge.
  task automatic abort_mid(input bit use_reset);
    wait_all_ready();
    op = 2'b00; operand = 32'h1; shamt = 5'd20; res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    @(negedge clk);
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int vld_hits;
    reset = 1'b1; flush = 1'b0; start = 1'b0; res_ready = 1'b1;
    op = 2'b00; operand = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_ready", W'(rdy), W'(4'hF));
    check("reset_valid", W'(vld), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("reset_result_step%0d", 1 << i), res[i], 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(2'b00, 32'h0000_0001, 5'd4, 1'b1, 1'b0);
    check("sll_ready_drop", W'(rdy_k1), 32'd0);
    check_txn("sll4", 32'h0000_0010, 5, 3, 2, 2);

    run_op(2'b11, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    check_txn("sra31", 32'hFFFF_FFFF, 32, 17, 9, 5);
    run_op(2'b01, 32'h8000_0000, 5'd31, 1'b1, 1'b0);
    check_txn("srl31", 32'h0000_0001, 32, 17, 9, 5);

    run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    check_txn("zero", 32'hDEAD_BEEF, 1, 1, 1, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("hold_valid_c%0d", c), W'(vld), W'(4'hF));
      for (int i = 0; i < N; i++)
        check($sformatf("hold_result_c%0d_step%0d", c, 1 << i), res[i], 32'hDEAD_BEEF);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_release_ready", W'(rdy), W'(4'hF));

    abort_mid(1'b0);
    check("flush_ready", W'(rdy), W'(4'hF));
    check("flush_valid", W'(vld), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("flush_result_step%0d", 1 << i), res[i], 32'hDEAD_BEEF);
    vld_hits = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (vld !== '0) vld_hits++;
    end
    check("flush_no_valid", W'(vld_hits), 32'd0);

    op = 2'b00; operand = 32'h5; shamt = 5'd3; flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_start_dropped", W'(rdy), W'(4'hF));

    run_op(2'b00, 32'h0000_0003, 5'd8, 1'b1, 1'b1);
    check_txn("busy_start", 32'h0000_0300, 9, 5, 3, 2);

    run_op(2'b10, 32'h0000_00F1, 5'd4, 1'b1, 1'b0);
`ifdef SHIFT_ROTATE_EN
    check_txn("rotr4", 32'h1000_000F, 5, 3, 2, 2);
`else
    check_txn("rotr4", 32'h0000_000F, 5, 3, 2, 2);
`endif

    abort_mid(1'b1);
    check("rst_mid_ready", W'(rdy), W'(4'hF));
    check("rst_mid_valid", W'(vld), 32'd0);
    for (int i = 0; i < N; i++) check($sformatf("rst_mid_result_step%0d", 1 << i), res[i], 32'd0);
    run_op(2'b00, 32'h0000_0003, 5'd2, 1'b1, 1'b0);
    check_txn("after_rst", 32'h0000_000C, 3, 2, 2, 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
